// File: rtl/ps2_host_if.sv
// ----------------------------------------------------------------------------
// ps2_host_if
// Byte-level handshake bundle between the PS/2 host controller and the
// keyboard/mouse decoder logic.
//   tx_valid/tx_data/tx_ready : host byte request (accepted on valid & ready)
//   tx_done/tx_err            : end-of-transmit pulse, err = no ACK or timeout
//   rx_valid/rx_data/rx_ready : FWFT receive FIFO head, pop on valid & ready
//   rx_count                  : receive FIFO occupancy (0..RX_DEPTH)
// master = decoder side, slave = controller side.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ps2_host_if #(
    parameter int RX_DEPTH = 8
);
    logic                        tx_valid;
    logic [7:0]                  tx_data;
    logic                        tx_ready;
    logic                        tx_done;
    logic                        tx_err;
    logic                        rx_valid;
    logic [7:0]                  rx_data;
    logic                        rx_ready;
    logic [$clog2(RX_DEPTH):0]   rx_count;

    modport master (
        output tx_valid, tx_data, rx_ready,
        input  tx_ready, tx_done, tx_err, rx_valid, rx_data, rx_count
    );

    modport slave (
        input  tx_valid, tx_data, rx_ready,
        output tx_ready, tx_done, tx_err, rx_valid, rx_data, rx_count
    );
endinterface

// File: rtl/ps2_host_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_host_ctrl
// PS/2 host controller: one arbitrated FSM for device-to-host receive and
// host-to-device transmit, raw pad synchronisers, a shared down-counting
// timer for inhibit hold and clock timeout, and a FWFT receive FIFO.
// Ports:
//   i_clk, i_rst        : system clock, synchronous active-high reset
//   i_ps2_clk/data      : raw PS/2 pad inputs
//   o_ps2_clk_oe/data_oe: 1 = pull the pad low, 0 = release
//   o_err_*             : single-cycle error pulses (parity, frame,
//                         timeout, overflow)
//   bus                 : byte TX/RX handshake (ps2_host_if.slave)
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | lines released, waiting for a start bit or a TX request
// RX        | shifting in d0..d7, parity, stop on device clock falls
// RX_CHK    | one cycle: check stop/parity, push or report
// TX_INH    | holding clock low for the inhibit time
// TX_DATA   | start bit driven; falls 1..10 present d0..d7, parity, stop
// TX_ACK    | waiting for the ACK fall, sample data
// TX_WAIT   | waiting for both lines to return high
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_host_ctrl #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 17,
    parameter int RX_DEPTH       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ps2_clk,
    input  logic        i_ps2_data,
    output logic        o_ps2_clk_oe,
    output logic        o_ps2_data_oe,
    output logic        o_err_parity,
    output logic        o_err_frame,
    output logic        o_err_timeout,
    output logic        o_err_overflow,
    ps2_host_if.slave   bus
);
    localparam int AW = $clog2(RX_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CNT_W-1:0] C_INH = CNT_W'(INHIBIT_CYCLES);
    localparam logic [CNT_W-1:0] C_TO  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_RX, S_RX_CHK, S_TX_INH, S_TX_DATA, S_TX_ACK, S_TX_WAIT
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_clk_s1, r_clk_s2, r_clk_prev;
    logic               r_data_s1, r_data_s2;
    logic [CNT_W-1:0]   r_timer, w_timer_nxt;
    logic [3:0]         r_bit_cnt, w_bit_nxt;
    logic [9:0]         r_rx_shift, w_rx_sh_nxt;
    logic [9:0]         r_tx_shift, w_tx_sh_nxt;
    logic               r_tx_err, w_tx_err_nxt;

    logic [7:0]         r_mem [RX_DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic w_fall, w_expired, w_pop, w_full, w_push;
    logic w_clk_oe, w_data_oe, w_tx_ready, w_tx_done, w_tx_err;
    logic w_err_par, w_err_frm, w_err_to, w_err_ovf;

    assign w_fall    = r_clk_prev & ~r_clk_s2;
    assign w_expired = (r_timer == '0);
    assign w_full    = (r_count == CW'(RX_DEPTH));
    assign w_pop     = (r_count != '0) & bus.rx_ready;

    // Pad synchronisers; preset high so reset never looks like a falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_data_s1  <= 1'b1;
            r_data_s2  <= 1'b1;
        end else begin
            r_clk_s1   <= i_ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_data_s1  <= i_ps2_data;
            r_data_s2  <= r_data_s1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_tx_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_rx_shift <= w_rx_sh_nxt;
            r_tx_shift <= w_tx_sh_nxt;
            r_tx_err   <= w_tx_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = w_expired ? r_timer : r_timer - 1'b1;
        w_bit_nxt    = r_bit_cnt;
        w_rx_sh_nxt  = r_rx_shift;
        w_tx_sh_nxt  = r_tx_shift;
        w_tx_err_nxt = r_tx_err;
        w_clk_oe     = 1'b0;
        w_data_oe    = 1'b0;
        w_tx_ready   = 1'b0;
        w_tx_done    = 1'b0;
        w_tx_err     = 1'b0;
        w_err_par    = 1'b0;
        w_err_frm    = 1'b0;
        w_err_to     = 1'b0;
        w_err_ovf    = 1'b0;
        w_push       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A falling edge this cycle belongs to the device, so TX waits.
                w_tx_ready = ~w_fall;
                if (w_fall && !r_data_s2) begin
                    w_state_nxt = S_RX;
                    w_bit_nxt   = '0;
                    w_timer_nxt = C_TO;
                end else if (!w_fall && bus.tx_valid) begin
                    // Frame LSB first: start, d0..d7, odd parity, stop.
                    w_tx_sh_nxt = {1'b1, ~^bus.tx_data, bus.tx_data, 1'b0};
                    w_timer_nxt = C_INH;
                    w_state_nxt = S_TX_INH;
                end
            end

            S_RX: begin
                if (w_expired) begin
                    w_err_to    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_fall) begin
                    w_rx_sh_nxt = {r_data_s2, r_rx_shift[9:1]};
                    w_timer_nxt = C_TO;
                    if (r_bit_cnt == 4'd9) begin
                        w_state_nxt = S_RX_CHK;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 1'b1;
                    end
                end
            end

            S_RX_CHK: begin
                w_state_nxt = S_IDLE;
                if (!r_rx_shift[9]) begin
                    w_err_frm = 1'b1;
                end else if (!(^r_rx_shift[8:0])) begin
                    w_err_par = 1'b1;
                end else if (w_full && !w_pop) begin
                    w_err_ovf = 1'b1;
                end else begin
                    w_push = 1'b1;
                end
            end

            S_TX_INH: begin
                if (w_expired) begin
                    w_data_oe   = 1'b1;
                    w_timer_nxt = C_TO;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_TX_DATA;
                end else begin
                    w_clk_oe = 1'b1;
                end
            end

            S_TX_DATA: begin
                if (w_expired) begin
                    w_err_to    = 1'b1;
                    w_tx_done   = 1'b1;
                    w_tx_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_data_oe = ~r_tx_shift[0];
                    if (w_fall) begin
                        w_tx_sh_nxt = {1'b1, r_tx_shift[9:1]};
                        w_timer_nxt = C_TO;
                        if (r_bit_cnt == 4'd9) begin
                            w_state_nxt = S_TX_ACK;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end
            end

            S_TX_ACK: begin
                if (w_expired) begin
                    w_err_to    = 1'b1;
                    w_tx_done   = 1'b1;
                    w_tx_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_fall) begin
                    w_tx_err_nxt = r_data_s2;
                    w_timer_nxt  = C_TO;
                    w_state_nxt  = S_TX_WAIT;
                end
            end

            S_TX_WAIT: begin
                if (w_expired) begin
                    w_err_to    = 1'b1;
                    w_tx_done   = 1'b1;
                    w_tx_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_clk_s2 && r_data_s2) begin
                    w_tx_done   = 1'b1;
                    w_tx_err    = r_tx_err;
                    w_state_nxt = S_IDLE;
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Receive FIFO: a push and a pop in the same cycle leave the count alone,
    // which is what lets a full FIFO accept a byte while its head is popped.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_rx_shift[7:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign o_ps2_clk_oe   = w_clk_oe;
    assign o_ps2_data_oe  = w_data_oe;
    assign o_err_parity   = w_err_par;
    assign o_err_frame    = w_err_frm;
    assign o_err_timeout  = w_err_to;
    assign o_err_overflow = w_err_ovf;

    assign bus.tx_ready = w_tx_ready;
    assign bus.tx_done  = w_tx_done;
    assign bus.tx_err   = w_tx_err;
    assign bus.rx_valid = (r_count != '0);
    assign bus.rx_data  = r_mem[r_rd_ptr];
    assign bus.rx_count = r_count;
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_ctrl
// Directed bench for ps2_host_ctrl with a behavioural PS/2 device on
// open-drain pads (pull-up modelled as AND of device and host release).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_host_ctrl;
    localparam int INH   = 20;
    localparam int TO    = 200;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic pad_clk, pad_data;
    logic clk_oe, data_oe;
    logic e_par, e_frm, e_to, e_ovf;

    int n_cmp = 0;
    int n_mis = 0;
    int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0;
    int n_done = 0, n_to_done = 0;
    logic last_tx_err = 1'b0;

    ps2_host_if #(.RX_DEPTH(DEPTH)) bus ();

    assign pad_clk  = dev_clk & ~clk_oe;
    assign pad_data = dev_data & ~data_oe;

    ps2_host_ctrl #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (9),
        .RX_DEPTH       (DEPTH)
    ) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_ps2_clk      (pad_clk),
        .i_ps2_data     (pad_data),
        .o_ps2_clk_oe   (clk_oe),
        .o_ps2_data_oe  (data_oe),
        .o_err_parity   (e_par),
        .o_err_frame    (e_frm),
        .o_err_timeout  (e_to),
        .o_err_overflow (e_ovf),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (e_par) n_par++;
        if (e_frm) n_frm++;
        if (e_to)  n_to++;
        if (e_ovf) n_ovf++;
        if (bus.tx_done) begin
            n_done++;
            last_tx_err = bus.tx_err;
            if (e_to && bus.tx_err) n_to_done++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One device-driven bit: data set, clock low 8 cycles, high again.
    task automatic dev_bit(input logic b);
        @(negedge clk);
        dev_data = b;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (8) @(negedge clk);
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Data, parity and stop bits. mode 1 checks push latency, mode 2 pops
    // during the RX_CHK cycle.
    task automatic send_tail(input logic [7:0] d, input logic par, input logic stop, input int mode);
        for (int i = 0; i < 8; i++) dev_bit(d[i]);
        dev_bit(par);
        @(negedge clk);
        dev_data = stop;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        if (mode == 1) chk("lat_rx_chk", bus.rx_valid, 0);
        if (mode == 2) bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
        if (mode == 1) chk("lat_push", bus.rx_valid, 1);
        repeat (4) @(negedge clk);
        dev_clk = 1'b1;
        dev_data = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int mode);
        dev_bit(1'b0);
        send_tail(d, par, stop, mode);
    endtask

    task automatic pop_chk(input logic [7:0] exp);
        chk("pop_valid", bus.rx_valid, 1);
        chk("pop_data", bus.rx_data, exp);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        bus.rx_ready = 1'b0;
    endtask

    // Request a byte; returns the number of cycles the clock was inhibited.
    task automatic tx_start(input logic [7:0] d, output int inh);
        @(negedge clk);
        chk("tx_ready_idle", bus.tx_ready, 1);
        bus.tx_valid = 1'b1;
        bus.tx_data  = d;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        inh = 0;
        while (clk_oe && inh < 1000) begin
            inh++;
            @(negedge clk);
        end
    endtask

    // Device generates n clocks and samples the pad data on each rising edge.
    task automatic dev_clocks(input int n, output logic [9:0] cap);
        cap = '0;
        for (int i = 0; i < n; i++) begin
            repeat (4) @(negedge clk);
            dev_clk = 1'b0;
            repeat (8) @(negedge clk);
            dev_clk = 1'b1;
            if (i < 10) cap[i] = pad_data;
        end
    endtask

    task automatic dev_ack(input logic ack);
        repeat (2) @(negedge clk);
        dev_data = ~ack;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (8) @(negedge clk);
        dev_clk = 1'b1;
        repeat (2) @(negedge clk);
        dev_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_par, s_frm, s_to, s_ovf, s_done, s_tod;
        int inh, cnt;
        logic [9:0] cap;
        logic [7:0] d;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_data_oe", data_oe, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_count", bus.rx_count, 0);
        chk("rst_tx_ready", bus.tx_ready, 1);

        // Good frame, then parity and stop errors.
        s_par = n_par; s_frm = n_frm; s_to = n_to; s_ovf = n_ovf;
        send_frame(8'h1C, 1'b0, 1'b1, 1);
        chk("rx1_valid", bus.rx_valid, 1);
        chk("rx1_data", bus.rx_data, 8'h1C);
        chk("rx1_count", bus.rx_count, 1);
        chk("rx1_no_err", (n_par - s_par) + (n_frm - s_frm) + (n_to - s_to) + (n_ovf - s_ovf), 0);

        s_par = n_par; s_frm = n_frm;
        send_frame(8'h1C, 1'b1, 1'b1, 0);
        chk("par_pulse", n_par - s_par, 1);
        chk("par_no_frm", n_frm - s_frm, 0);
        chk("par_count", bus.rx_count, 1);

        s_par = n_par; s_frm = n_frm;
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        chk("frm_pulse", n_frm - s_frm, 1);
        chk("frm_no_par", n_par - s_par, 0);
        chk("frm_count", bus.rx_count, 1);
        pop_chk(8'h1C);
        chk("empty_after_pop", bus.rx_count, 0);

        // Overflow: nine frames into eight entries.
        s_ovf = n_ovf; s_par = n_par;
        for (int i = 1; i <= 9; i++) begin
            d = 8'(i);
            send_frame(d, ~^d, 1'b1, 0);
        end
        chk("ovf_count", bus.rx_count, 8);
        chk("ovf_pulse", n_ovf - s_ovf, 1);
        chk("ovf_no_par", n_par - s_par, 0);
        for (int i = 1; i <= 8; i++) pop_chk(8'(i));
        chk("ovf_drained", bus.rx_count, 0);

        // Pop during the ninth RX_CHK: byte accepted, no overflow.
        s_ovf = n_ovf;
        for (int i = 1; i <= 8; i++) begin
            d = 8'(i);
            send_frame(d, ~^d, 1'b1, 0);
        end
        chk("full_count", bus.rx_count, 8);
        send_frame(8'h09, 1'b1, 1'b1, 2);
        chk("pushpop_no_ovf", n_ovf - s_ovf, 0);
        chk("pushpop_count", bus.rx_count, 8);
        for (int i = 2; i <= 9; i++) pop_chk(8'(i));

        // Transmit 0xED with ACK.
        s_done = n_done; s_to = n_to;
        tx_start(8'hED, inh);
        chk("tx_inhibit_len", inh, INH);
        chk("tx_start_bit", data_oe, 1);
        dev_clocks(10, cap);
        chk("tx_bits", cap, 10'h3ED);
        dev_ack(1'b1);
        chk("tx_done_ack", n_done - s_done, 1);
        chk("tx_err_ack", last_tx_err, 0);
        chk("tx_no_to", n_to - s_to, 0);

        // Same without ACK.
        s_done = n_done;
        tx_start(8'hED, inh);
        dev_clocks(10, cap);
        chk("tx2_bits", cap, 10'h3ED);
        dev_ack(1'b0);
        chk("tx_done_nack", n_done - s_done, 1);
        chk("tx_err_nack", last_tx_err, 1);

        // RX timeout after start + 4 data bits.
        s_to = n_to;
        dev_bit(1'b0);
        for (int i = 0; i < 4; i++) dev_bit(1'b1);
        cnt = 0;
        while (!e_to && cnt < TO + 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("rx_to_latency", cnt, TO - 9);
        @(negedge clk);
        chk("rx_to_pulse", n_to - s_to, 1);
        chk("rx_to_idle_ready", bus.tx_ready, 1);
        chk("rx_to_count", bus.rx_count, 0);

        // TX timeout after 3 device clocks.
        s_to = n_to; s_done = n_done; s_tod = n_to_done;
        tx_start(8'hED, inh);
        dev_clocks(3, cap);
        repeat (TO + 20) @(negedge clk);
        chk("txto_to_pulse", n_to - s_to, 1);
        chk("txto_done", n_done - s_done, 1);
        chk("txto_same_cycle", n_to_done - s_tod, 1);
        chk("txto_data_rel", data_oe, 0);
        chk("txto_idle_ready", bus.tx_ready, 1);

        // Start edge coincident with tx_valid: RX wins.
        s_done = n_done;
        @(negedge clk);
        dev_data = 1'b0;
        repeat (4) @(negedge clk);
        dev_clk = 1'b0;
        repeat (2) @(negedge clk);
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'h33;
        chk("coinc_tx_ready", bus.tx_ready, 0);
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b1;
        repeat (4) @(negedge clk);
        send_tail(8'hA5, 1'b1, 1'b1, 0);
        chk("coinc_count", bus.rx_count, 1);
        chk("coinc_data", bus.rx_data, 8'hA5);
        chk("coinc_no_tx", n_done - s_done, 0);
        chk("coinc_clk_rel", clk_oe, 0);

        // Reset in the middle of TX_DATA.
        tx_start(8'h00, inh);
        dev_clocks(3, cap);
        chk("midtx_driving", data_oe, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midtx_rst_clk_oe", clk_oe, 0);
        chk("midtx_rst_data_oe", data_oe, 0);
        chk("midtx_rst_valid", bus.rx_valid, 0);
        chk("midtx_rst_count", bus.rx_count, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
